crc_checker: RTL
================

Name: crc_checker

Overview:
- Receive-side counterpart of the team's serial CRC generator.
- Accepts a 17-bit codeword (14 data bits followed by a 3-bit CRC) and the same 4-bit divisor.
- Performs bit-serial modulo-2 long division, one quotient bit per clock, and reports the 3-bit syndrome, an error flag and the extracted data word.
- Sits on the receive path after codeword assembly and before the data consumer.

Parameters:
DATA_W, 14, data bits in codeword
CRC_W, 3, CRC bits; divisor width is CRC_W+1; codeword width is DATA_W+CRC_W

Ports:
clk  input  1  clock, rising-edge
Reset  input  1  asynchronous, active-low reset
E  input  1  start; sampled only in IDLE
Codeword  input  17  received word; bits [16:3] data, [2:0] CRC
Divisor  input  4  generator polynomial; bit 3 is x^3, must be 1
Busy  output  1  high while a check is in progress
Done  output  1  one-cycle completion pulse
Data  output  14  Codeword[16:3] of last completed check
Syndrome  output  3  remainder of last completed check
Error  output  1  high when Syndrome != 0 or divisor invalid
BadDiv  output  1  high when last captured Divisor[3] == 0

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE.
  - Busy, Done, Error and BadDiv go to 0.
  - Data and Syndrome go to 0.
  - Internal work register A[16:0], latched divisor D[3:0] and counter cnt go to 0.
  - Reset asserted mid-division aborts the operation; no Done is produced.
- States: IDLE, DIV, FINISH.
- IDLE:
  - On a rising edge with E=1, latch A<=Codeword and D<=Divisor.
  - Set cnt<=DATA_W-1 (13) and Busy<=1.
  - If Divisor[3]==1, go to DIV; otherwise go to FINISH with the bad-divisor flag set.
  - E=0 keeps the block in IDLE.
- DIV:
  - Each edge processes bit index k = CRC_W+cnt (16 down to 3).
  - If A[k]==1, then A[k:k-3] <= A[k:k-3] ^ D; otherwise A is unchanged.
  - If cnt==0, go to FINISH; otherwise cnt<=cnt-1.
  - Exactly 14 DIV cycles per check, independent of data; no early exit on leading zeros.
- FINISH, one cycle:
  - Syndrome <= bad-divisor ? 3'b111 : A[2:0].
  - BadDiv <= bad-divisor flag.
  - Error <= bad-divisor | (|A[2:0]).
  - Data <= latched Codeword[16:3].
  - Done<=1 for this one cycle only; Busy<=0; go to IDLE.
- Latency:
  - Valid divisor: E sampled at edge N gives Done high after edge N+15, for one cycle.
  - Invalid divisor: Done high after edge N+1.
- Handshake:
  - E is ignored while Busy=1 and in the FINISH cycle; a new check is accepted at the first IDLE edge after Done.
  - Codeword and Divisor are sampled only at the accepting edge; later changes have no effect.
- Outputs Data, Syndrome, Error and BadDiv hold their values until the next FINISH; they are not cleared on a new start.
- Arithmetic: all operations are GF(2) (XOR only), with no carries; bits above the current index k are never modified.

Test Plan:
1. Divisor=4'b1011, Codeword=17'h1A764 (data 14'h34EC, CRC 3'b100), E pulsed at edge N -> Done at N+15, Syndrome=3'b000, Error=0, BadDiv=0, Data=14'h34EC; Busy high for edges N..N+14.
2. Same as scenario 1 with Codeword=17'h1A765 (bit 0 flipped) -> Syndrome=3'b001, Error=1. Repeat with 17'h1A76C (bit 3 flipped) -> Syndrome=3'b011, Error=1, Data=14'h34ED.
3. Codeword=17'h00000, Divisor=4'b1011 -> Done still at N+15, Syndrome=0, Error=0.
4. Divisor=4'b0011 with any Codeword -> Done at N+1, BadDiv=1, Error=1, Syndrome=3'b111.
5. Start scenario 1, then toggle E and change Codeword at N+5 -> result identical to scenario 1 and only one Done. Start again with E held high through Done -> second check accepted at the first IDLE edge after Done.
6. Start scenario 2, then assert Reset low at N+7 for 2 cycles -> Busy=0 and all outputs 0 immediately, no Done. After release, scenario 1 runs correctly.

Source files
------------

// File: rtl/crc_checker.sv
// -----------------------------------------------------------------------------
// crc_checker
//
// Receive-side CRC checker. It takes a codeword made of DATA_W data bits
// followed by CRC_W CRC bits and divides it by the generator polynomial
// (CRC_W+1 bits) using bit-serial modulo-2 long division. One quotient bit is
// produced per clock, so a check always takes exactly DATA_W division cycles.
// When the division finishes, the block reports the remainder (syndrome), an
// error flag and the data field of the codeword.
//
// Ports
//   clk       in   rising-edge clock
//   Reset     in   asynchronous, active-low reset
//   E         in   start request, sampled only while idle
//   Codeword  in   [DATA_W+CRC_W-1:0] received word: data on top, CRC below
//   Divisor   in   [CRC_W:0] generator polynomial; the top bit must be 1
//   Busy      out  high from the accepting edge until the result is written
//   Done      out  one-cycle pulse when a result has been written
//   Data      out  [DATA_W-1:0] data field of the last completed check
//   Syndrome  out  [CRC_W-1:0] remainder of the last completed check
//                  (all ones when the divisor was invalid)
//   Error     out  nonzero syndrome or invalid divisor
//   BadDiv    out  top bit of the last captured divisor was 0
//
// Data, Syndrome, Error and BadDiv hold until the next check completes; they
// are not cleared when a new check starts.
// -----------------------------------------------------------------------------
module crc_checker #(
    parameter int DATA_W = 14,
    parameter int CRC_W  = 3
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      E,
    input  logic [DATA_W+CRC_W-1:0]   Codeword,
    input  logic [CRC_W:0]            Divisor,
    output logic                      Busy,
    output logic                      Done,
    output logic [DATA_W-1:0]         Data,
    output logic [CRC_W-1:0]          Syndrome,
    output logic                      Error,
    output logic                      BadDiv
);

    localparam int CW_W  = DATA_W + CRC_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam int K_W   = $clog2(CW_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // One long-division step at bit k = CRC_W + cnt. The divisor, aligned so
    // its top bit lands on k, is XORed in only when A[k] is set. Bits above k
    // are never touched because the shifted divisor has zeros there.
    function automatic logic [CW_W-1:0] div_step(
        input logic [CW_W-1:0]  a,
        input logic [CRC_W:0]   d,
        input logic [CNT_W-1:0] cnt
    );
        logic [CW_W-1:0] aligned_d;
        logic [K_W-1:0]  k;
        k         = K_W'(CRC_W) + K_W'(cnt);
        aligned_d = CW_W'(d) << cnt;
        if (a[k]) begin
            div_step = a ^ aligned_d;
        end else begin
            div_step = a;
        end
    endfunction

    state_t              state_r,     state_s;
    logic [CW_W-1:0]     a_r,         a_s;
    logic [CRC_W:0]      d_r,         d_s;
    logic [CNT_W-1:0]    cnt_r,       cnt_s;
    logic                bad_r,       bad_s;
    logic [DATA_W-1:0]   data_hold_r, data_hold_s;
    logic                busy_s;
    logic                done_s;
    logic [DATA_W-1:0]   data_s;
    logic [CRC_W-1:0]    syndrome_s;
    logic                error_s;
    logic                bad_div_s;

    // FSM state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-value logic for the work registers and outputs.
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        d_s         = d_r;
        cnt_s       = cnt_r;
        bad_s       = bad_r;
        data_hold_s = data_hold_r;
        busy_s      = Busy;
        done_s      = 1'b0;
        data_s      = Data;
        syndrome_s  = Syndrome;
        error_s     = Error;
        bad_div_s   = BadDiv;

        case (state_r)
            ST_IDLE: begin
                if (E) begin
                    a_s         = Codeword;
                    d_s         = Divisor;
                    data_hold_s = Codeword[CW_W-1:CRC_W];
                    cnt_s       = CNT_W'(DATA_W - 1);
                    busy_s      = 1'b1;
                    // An invalid divisor skips the division entirely.
                    bad_s       = ~Divisor[CRC_W];
                    if (Divisor[CRC_W]) begin
                        state_s = ST_DIV;
                    end else begin
                        state_s = ST_FINISH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_DIV: begin
                a_s = div_step(a_r, d_r, cnt_r);
                if (cnt_r == CNT_W'(0)) begin
                    state_s = ST_FINISH;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end

            ST_FINISH: begin
                if (bad_r) begin
                    syndrome_s = {CRC_W{1'b1}};
                end else begin
                    syndrome_s = a_r[CRC_W-1:0];
                end
                bad_div_s = bad_r;
                error_s   = bad_r | (|a_r[CRC_W-1:0]);
                // A's upper bits were consumed by the division, so the data
                // field comes from the copy taken at the accepting edge.
                data_s    = data_hold_r;
                done_s    = 1'b1;
                busy_s    = 1'b0;
                state_s   = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Work registers and registered outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            a_r         <= {CW_W{1'b0}};
            d_r         <= {(CRC_W+1){1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            bad_r       <= 1'b0;
            data_hold_r <= {DATA_W{1'b0}};
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Data        <= {DATA_W{1'b0}};
            Syndrome    <= {CRC_W{1'b0}};
            Error       <= 1'b0;
            BadDiv      <= 1'b0;
        end else begin
            a_r         <= a_s;
            d_r         <= d_s;
            cnt_r       <= cnt_s;
            bad_r       <= bad_s;
            data_hold_r <= data_hold_s;
            Busy        <= busy_s;
            Done        <= done_s;
            Data        <= data_s;
            Syndrome    <= syndrome_s;
            Error       <= error_s;
            BadDiv      <= bad_div_s;
        end
    end

endmodule
